// File: rtl/gf_sbox_scheduler.sv
// Time-multiplexes one shared 32-bit S-box datapath over a 128-bit AES state:
// four words are issued back to back, results are collected after SB_LAT cycles.

module gf_sbox_word_slot #(
  parameter int VEC_W = 32,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tag,
  input  logic [1:0]       ret_cnt,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            q <= '0;
    else if (tag && (ret_cnt == 2'(IDX)))  q <= din;
  end
endmodule

module gf_sbox_scheduler #(
  parameter int SB_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         sb_valid,
  output logic [31:0]  sb_data_out,
  output logic         sb_inv,
  input  logic [31:0]  sb_data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NUM_WORDS = 4;
  localparam int VEC_W     = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [NUM_WORDS-1:0][VEC_W-1:0] words;
    logic                            inv;
  } sb_req_t;

  state_t                          state, state_nxt;
  sb_req_t                         req_q;
  logic [1:0]                      iss_cnt, ret_cnt;
  logic [SB_LAT:1]                 vld_sr;
  logic [SB_LAT:0]                 vld_pipe;
  logic [NUM_WORDS-1:0][VEC_W-1:0] res_q;
  logic                            accept, ret_tag, last_ret;

  assign accept   = in_valid && in_ready;
  // vld_pipe[k] is sb_valid delayed k cycles; the top tap marks a returning word
  assign vld_pipe = {vld_sr, sb_valid};
  assign ret_tag  = vld_pipe[SB_LAT];
  assign last_ret = ret_tag && (ret_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = ISSUE;
      ISSUE:   if (iss_cnt == 2'd3)  state_nxt = DRAIN;
      DRAIN:   if (last_ret)         state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
      vld_sr  <= '0;
    end else begin
      if (accept) begin
        req_q.words <= in_data;
        req_q.inv   <= in_inv;
      end
      iss_cnt <= (state == ISSUE) ? iss_cnt + 2'd1 : 2'd0;
      if (ret_tag)             ret_cnt <= ret_cnt + 2'd1;
      else if (state == IDLE)  ret_cnt <= '0;
      vld_sr <= vld_pipe[SB_LAT-1:0];
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
    gf_sbox_word_slot #(.VEC_W(VEC_W), .IDX(k)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag     (ret_tag),
      .ret_cnt (ret_cnt),
      .din     (sb_data_in),
      .q       (res_q[k])
    );
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign sb_valid    = (state == ISSUE);
  assign sb_data_out = sb_valid ? req_q.words[iss_cnt] : '0;
  assign sb_inv      = req_q.inv;
  assign out_valid   = (state == DONE);
  assign out_data    = res_q;
endmodule
